// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors definitions: move encodings, game rules,
// predictor FSM states and the tie-break LFSR taps.
package rps_pkg;

    localparam logic [1:0] ROCK     = 2'b00;
    localparam logic [1:0] SCISSORS = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] ILLEGAL  = 2'b11;

    // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {WIN, LOSS, DRAW} outcome_t;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_RD, ST_WR, ST_PRED} state_t;

    function automatic logic [1:0] beat(input logic [1:0] m);
        case (m)
            ROCK:     return PAPER;
            SCISSORS: return ROCK;
            default:  return SCISSORS;
        endcase
    endfunction

    // Result seen from the computer's side.
    function automatic outcome_t outcome(input logic [1:0] u, input logic [1:0] c);
        if (u == c)
            return DRAW;
        else if (c == beat(u))
            return WIN;
        else
            return LOSS;
    endfunction

endpackage

// File: rtl/rps_argmax.sv
// Index of the largest of three counters with LFSR-driven tie-breaking:
// two-way ties use lfsr_lo[0] (0 = lower index), three-way ties use lfsr_lo (3 -> 0).
module rps_argmax
    import rps_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    input  logic [CNT_W-1:0] cnt2,
    input  logic [1:0]       lfsr_lo,
    output logic [1:0]       p
);

    logic [CNT_W-1:0] max01;
    logic [CNT_W-1:0] max_all;
    logic [2:0]       is_max;

    always_comb begin
        max01   = (cnt0 >= cnt1) ? cnt0 : cnt1;
        max_all = (max01 >= cnt2) ? max01 : cnt2;
        is_max  = {cnt2 == max_all, cnt1 == max_all, cnt0 == max_all};
        p       = 2'd0;
        case (is_max)
            3'b111:  p = (lfsr_lo == 2'd3) ? 2'd0 : lfsr_lo;
            3'b011:  p = lfsr_lo[0] ? 2'd1 : 2'd0;
            3'b101:  p = lfsr_lo[0] ? 2'd2 : 2'd0;
            3'b110:  p = lfsr_lo[0] ? 2'd2 : 2'd1;
            3'b010:  p = 2'd1;
            3'b100:  p = 2'd2;
            default: p = 2'd0;
        endcase
    end

endmodule

// File: rtl/markov_predictor.sv
// Rock-paper-scissors opponent: per-context move frequency table over the last
// HIST rounds, plays the move that beats the user's most likely next move.
module markov_predictor
    import rps_pkg::*;
#(
    parameter int          HIST    = 2,
    parameter int          CNT_W   = 8,
    parameter int          SCORE_W = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         user,
    output logic [1:0]         choice,
    output logic               ready,
    output logic               err,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses,
    output logic [SCORE_W-1:0] draws
);

    localparam int NCTX    = 9 ** HIST;
    localparam int NSUB    = NCTX / 9;
    localparam int CTX_W   = $clog2(NCTX);
    localparam int INIT_W  = $clog2(NCTX + 1);
    localparam int ENTRY_W = 3 * CNT_W;

    state_t             state_q, state_d;
    logic [CTX_W-1:0]   ctx_q, ctx_d;
    logic [INIT_W-1:0]  init_q, init_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [1:0]         choice_q, choice_d;
    logic               err_q, err_d;
    logic [1:0]         u_q, u_d, c_q, c_d;
    logic [SCORE_W-1:0] wins_q, wins_d, losses_q, losses_d, draws_q, draws_d;

    logic [ENTRY_W-1:0] mem [NCTX];
    logic [ENTRY_W-1:0] rdata_q;
    logic [ENTRY_W-1:0] mem_wdata, entry_upd;
    logic [CTX_W-1:0]   mem_addr;
    logic               mem_we;

    logic [CNT_W-1:0]   cnt [3];
    logic [CNT_W-1:0]   cnt_upd [3];
    logic               sel_full;
    logic [1:0]         pred_idx;

    // Single-port table: a write cycle does not refresh the read register.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        else
            rdata_q <= mem[mem_addr];
    end

    always_comb begin
        for (int i = 0; i < 3; i++) cnt[i] = rdata_q[i*CNT_W +: CNT_W];
        sel_full = 1'b0;
        for (int i = 0; i < 3; i++)
            if (u_q == 2'(i) && cnt[i] == '1) sel_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt_upd[i] = sel_full ? (cnt[i] >> 1) : cnt[i];
            if (u_q == 2'(i)) cnt_upd[i] = cnt_upd[i] + CNT_W'(1);
        end
        entry_upd = {cnt_upd[2], cnt_upd[1], cnt_upd[0]};
    end

    rps_argmax #(.CNT_W(CNT_W)) u_argmax (
        .cnt0    (cnt[0]),
        .cnt1    (cnt[1]),
        .cnt2    (cnt[2]),
        .lfsr_lo (lfsr_q[1:0]),
        .p       (pred_idx)
    );

    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_comb begin
        state_d   = state_q;
        ctx_d     = ctx_q;
        init_d    = init_q;
        choice_d  = choice_q;
        err_d     = 1'b0;
        u_d       = u_q;
        c_d       = c_q;
        wins_d    = wins_q;
        losses_d  = losses_q;
        draws_d   = draws_q;
        mem_we    = 1'b0;
        mem_addr  = ctx_q;
        mem_wdata = '0;
        case (state_q)
            // After the last zero write, one extra cycle reads entry 0 for the first prediction.
            ST_INIT: begin
                if (init_q < INIT_W'(NCTX)) begin
                    mem_we   = reset;
                    mem_addr = CTX_W'(init_q);
                    init_d   = init_q + INIT_W'(1);
                end else begin
                    state_d = ST_PRED;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    if (user == ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        u_d = user;
                        c_d = choice_q;
                        case (outcome(user, choice_q))
                            WIN:     wins_d   = (&wins_q)   ? wins_q   : wins_q + SCORE_W'(1);
                            LOSS:    losses_d = (&losses_q) ? losses_q : losses_q + SCORE_W'(1);
                            default: draws_d  = (&draws_q)  ? draws_q  : draws_q + SCORE_W'(1);
                        endcase
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_we    = reset;
                mem_wdata = entry_upd;
                ctx_d     = CTX_W'((int'(ctx_q) % NSUB) * 9 + int'(u_q) * 3 + int'(c_q));
                state_d   = ST_WR;
            end
            ST_WR:   state_d = ST_PRED;
            ST_PRED: begin
                choice_d = beat(pred_idx);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            ctx_q    <= '0;
            init_q   <= '0;
            lfsr_q   <= SEED;
            choice_q <= ROCK;
            err_q    <= 1'b0;
            u_q      <= ROCK;
            c_q      <= ROCK;
            wins_q   <= '0;
            losses_q <= '0;
            draws_q  <= '0;
        end else begin
            state_q  <= state_d;
            ctx_q    <= ctx_d;
            init_q   <= init_d;
            lfsr_q   <= lfsr_d;
            choice_q <= choice_d;
            err_q    <= err_d;
            u_q      <= u_d;
            c_q      <= c_d;
            wins_q   <= wins_d;
            losses_q <= losses_d;
            draws_q  <= draws_d;
        end
    end

    assign choice = choice_q;
    assign ready  = (state_q == ST_IDLE);
    assign err    = err_q;
    assign wins   = wins_q;
    assign losses = losses_q;
    assign draws  = draws_q;

endmodule

// File: tb/tb_markov_predictor.sv
// Directed bench: two predictor instances (HIST=2/8-bit and HIST=1/2-bit)
// checked round by round against a behavioural opponent model.
module tb_markov_predictor;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [1:0] user_a, user_b;
    logic [1:0] choice_a, choice_b;
    logic       ready_a, ready_b, err_a, err_b;
    logic [7:0] wins_a, losses_a, draws_a;
    logic [1:0] wins_b, losses_b, draws_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    markov_predictor #(.HIST(2), .CNT_W(8), .SCORE_W(8), .SEED(16'hACE1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .user(user_a),
        .choice(choice_a), .ready(ready_a), .err(err_a),
        .wins(wins_a), .losses(losses_a), .draws(draws_a)
    );

    markov_predictor #(.HIST(1), .CNT_W(2), .SCORE_W(2), .SEED(16'hACE1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .user(user_b),
        .choice(choice_b), .ready(ready_b), .err(err_b),
        .wins(wins_b), .losses(losses_b), .draws(draws_b)
    );

    // Reference tie-break LFSR: taps 16,14,13,11, shifting left.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int m_tab [2][81][3];
    int m_ctx [2];
    int m_choice [2];
    int m_w [2];
    int m_l [2];
    int m_d [2];
    int nctx [2] = '{81, 9};
    int cmax [2] = '{255, 3};
    int smax [2] = '{255, 3};

    int mix_b [20] = '{1, 1, 2, 0, 1, 2, 2, 0, 0, 1, 2, 1, 0, 0, 2, 1, 1, 1, 0, 2};
    int mix_a [8]  = '{2, 1, 0, 0, 2, 1, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int beat_m(input int m);
        return (m == 0) ? 2 : (m == 1) ? 0 : 1;
    endfunction

    function automatic int pick(input int a, input int b, input int c, input logic [15:0] l);
        int v [3];
        int mx, n, lo, hi;
        v = '{a, b, c};
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        n = 0; lo = -1; hi = -1;
        for (int i = 0; i < 3; i++)
            if (v[i] == mx) begin
                n++;
                if (lo < 0) lo = i;
                hi = i;
            end
        if (n == 1) return lo;
        if (n == 2) return l[0] ? hi : lo;
        return (l[1:0] == 2'd3) ? 0 : int'(l[1:0]);
    endfunction

    function automatic logic [31:0] f_ready(input int s);  return s == 0 ? 32'(ready_a)  : 32'(ready_b);  endfunction
    function automatic logic [31:0] f_choice(input int s); return s == 0 ? 32'(choice_a) : 32'(choice_b); endfunction
    function automatic logic [31:0] f_err(input int s);    return s == 0 ? 32'(err_a)    : 32'(err_b);    endfunction
    function automatic logic [31:0] f_wins(input int s);   return s == 0 ? 32'(wins_a)   : 32'(wins_b);   endfunction
    function automatic logic [31:0] f_losses(input int s); return s == 0 ? 32'(losses_a) : 32'(losses_b); endfunction
    function automatic logic [31:0] f_draws(input int s);  return s == 0 ? 32'(draws_a)  : 32'(draws_b);  endfunction

    task automatic drive(input int s, input logic st, input logic [1:0] u);
        if (s == 0) begin start_a = st; user_a = u; end
        else        begin start_b = st; user_b = u; end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 81; k++)
                for (int i = 0; i < 3; i++) m_tab[s][k][i] = 0;
            m_ctx[s] = 0; m_choice[s] = 0;
            m_w[s] = 0; m_l[s] = 0; m_d[s] = 0;
        end
    endtask

    task automatic model_round(input int s, input int u, input logic [15:0] lp);
        int c, cx;
        c  = m_choice[s];
        cx = m_ctx[s];
        if (u == c)                m_d[s] = (m_d[s] < smax[s]) ? m_d[s] + 1 : m_d[s];
        else if (c == beat_m(u))   m_w[s] = (m_w[s] < smax[s]) ? m_w[s] + 1 : m_w[s];
        else                       m_l[s] = (m_l[s] < smax[s]) ? m_l[s] + 1 : m_l[s];
        if (m_tab[s][cx][u] == cmax[s])
            for (int i = 0; i < 3; i++) m_tab[s][cx][i] = m_tab[s][cx][i] / 2;
        m_tab[s][cx][u] = m_tab[s][cx][u] + 1;
        m_ctx[s] = (cx * 9 + u * 3 + c) % nctx[s];
        cx = m_ctx[s];
        m_choice[s] = beat_m(pick(m_tab[s][cx][0], m_tab[s][cx][1], m_tab[s][cx][2], lp));
    endtask

    task automatic check_state(input int s, input string tag);
        check($sformatf("%s_choice%0d", tag, s), f_choice(s), 32'(m_choice[s]));
        check($sformatf("%s_wins%0d", tag, s),   f_wins(s),   32'(m_w[s]));
        check($sformatf("%s_losses%0d", tag, s), f_losses(s), 32'(m_l[s]));
        check($sformatf("%s_draws%0d", tag, s),  f_draws(s),  32'(m_d[s]));
    endtask

    // Entered at a negedge with the predictor idle; returns at the negedge after ready returns.
    task automatic do_round(input int s, input int u, input bit poke);
        logic [15:0] lp;
        drive(s, 1'b1, 2'(u));
        @(posedge clock); @(negedge clock);
        check($sformatf("rdy_t1_%0d", s), f_ready(s), 32'd0);
        if (poke) drive(s, 1'b1, 2'b11);
        else      drive(s, 1'b0, 2'(u) ^ 2'b01);
        @(posedge clock); @(negedge clock);
        check($sformatf("rdy_t2_%0d", s), f_ready(s), 32'd0);
        if (poke) check($sformatf("poke_err%0d", s), f_err(s), 32'd0);
        drive(s, 1'b0, 2'(u) ^ 2'b10);
        @(posedge clock); @(negedge clock);
        check($sformatf("rdy_t3_%0d", s), f_ready(s), 32'd0);
        lp = m_lfsr;
        @(posedge clock); @(negedge clock);
        check($sformatf("rdy_t4_%0d", s), f_ready(s), 32'd1);
        model_round(s, u, lp);
        check_state(s, "round");
    endtask

    // Entered at the negedge where reset has just been released.
    task automatic wait_init();
        int ea, eb;
        logic [15:0] prev, la, lb;
        ea = -1; eb = -1; la = '0; lb = '0;
        prev = m_lfsr;
        for (int k = 1; k <= 200 && (ea < 0 || eb < 0); k++) begin
            @(posedge clock); @(negedge clock);
            if (ready_a === 1'b1 && ea < 0) begin ea = k; la = prev; end
            if (ready_b === 1'b1 && eb < 0) begin eb = k; lb = prev; end
            prev = m_lfsr;
        end
        check("init_edges_a", 32'(ea), 32'd83);
        check("init_edges_b", 32'(eb), 32'd11);
        m_choice[0] = beat_m(pick(0, 0, 0, la));
        m_choice[1] = beat_m(pick(0, 0, 0, lb));
        check_state(0, "init");
        check_state(1, "init");
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 2'b00);
        drive(1, 1'b0, 2'b00);
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_choice_a", 32'(choice_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_wins_a", 32'(wins_a), 32'd0);
        reset = 1'b1;
        wait_init();

        // Five computer wins on the 2-bit-score instance: wins pins at 3.
        for (int i = 0; i < 5; i++) begin
            int c = m_choice[1];
            do_round(1, (c == 0) ? 1 : (c == 1) ? 2 : 0, 1'b0);
        end
        check("sat_wins", 32'(wins_b), 32'd3);
        check("sat_losses", 32'(losses_b), 32'd0);
        check("sat_draws", 32'(draws_b), 32'd0);

        // Repeated scissors drives 2-bit counters into ageing, then a mixed run.
        for (int i = 0; i < 6; i++) do_round(1, 1, 1'b0);
        check("age_choice", 32'(choice_b), 32'd0);
        foreach (mix_b[i]) do_round(1, mix_b[i], 1'b0);

        // Learning: constant rock on HIST=2 converges to paper.
        for (int i = 0; i < 8; i++) do_round(0, 0, 1'b0);
        check("learn_choice", 32'(choice_a), 32'd2);

        // Start during a round (with an illegal move) is ignored.
        do_round(0, 0, 1'b1);

        // Illegal move in IDLE: one-cycle err, nothing else moves.
        drive(0, 1'b1, 2'b11);
        @(posedge clock); @(negedge clock);
        check("ill_err_hi", 32'(err_a), 32'd1);
        check("ill_ready", 32'(ready_a), 32'd1);
        drive(0, 1'b0, 2'b00);
        @(posedge clock); @(negedge clock);
        check("ill_err_lo", 32'(err_a), 32'd0);
        check_state(0, "ill");

        foreach (mix_a[i]) do_round(0, mix_a[i], 1'b0);
        for (int i = 0; i < 4; i++) do_round(0, 0, 1'b0);

        // Reset arriving while the predictor is in WR.
        drive(0, 1'b1, 2'b00);
        @(posedge clock); @(negedge clock);
        drive(0, 1'b0, 2'b00);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        check("mid_rst_ready", 32'(ready_a), 32'd0);
        check("mid_rst_wins", 32'(wins_a), 32'd0);
        check("mid_rst_losses", 32'(losses_a), 32'd0);
        check("mid_rst_draws", 32'(draws_a), 32'd0);
        check("mid_rst_choice", 32'(choice_a), 32'd0);
        reset = 1'b1;
        model_reset();
        wait_init();
        for (int i = 0; i < 6; i++) do_round(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
